// File: rtl/class_hv_accum_if.sv
// Bundle of strobes, indices and results exchanged between the class-generation
// controller (master) and the class hypervector accumulator (slave).
interface class_hv_accum_if #(
  parameter int NUM_CLASSES = 4,
  parameter int SEG_COUNT   = 4,
  parameter int SEG_W       = 64,
  parameter int SAMPLE_W    = 16
);
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int SEG_IW = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;

  logic                          en;
  logic                          clr;
  logic                          acc_valid;
  logic [CLS_W-1:0]              acc_class;
  logic [SEG_IW-1:0]             acc_seg;
  logic [SEG_W-1:0]              acc_hv;
  logic                          bin_valid;
  logic [CLS_W-1:0]              bin_class;
  logic [SEG_IW-1:0]             bin_seg;
  logic                          out_valid;
  logic [CLS_W-1:0]              out_class;
  logic [SEG_IW-1:0]             out_seg;
  logic [SEG_W-1:0]              out_hv;
  logic [NUM_CLASSES*SAMPLE_W-1:0] sample_cnt;
  logic                          sat_flag;

  modport master (
    output en, clr, acc_valid, acc_class, acc_seg, acc_hv,
    output bin_valid, bin_class, bin_seg,
    input  out_valid, out_class, out_seg, out_hv, sample_cnt, sat_flag
  );

  modport slave (
    input  en, clr, acc_valid, acc_class, acc_seg, acc_hv,
    input  bin_valid, bin_class, bin_seg,
    output out_valid, out_class, out_seg, out_hv, sample_cnt, sat_flag
  );
endinterface

// File: rtl/class_hv_accum.sv
// Class hypervector store: saturating bipolar accumulation of sample segments
// and sign-bit readout of class segments with one cycle of latency.
module class_hv_accum #(
  parameter int NUM_CLASSES = 4,
  parameter int SEG_COUNT   = 4,
  parameter int SEG_W       = 64,
  parameter int CNT_W       = 8,
  parameter int SAMPLE_W    = 16
) (
  input  logic             clk,
  input  logic             nrst,
  class_hv_accum_if.slave  hv
);
  localparam int CLS_W  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int SEG_IW = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;

  localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SEG_IW-1:0]       SEG_LAST = SEG_IW'(SEG_COUNT - 1);

  logic signed [CNT_W-1:0] cnt_q [NUM_CLASSES][SEG_COUNT][SEG_W];
  logic [SAMPLE_W-1:0]     sample_q [NUM_CLASSES];
  logic                    sat_q;
  logic                    out_valid_q;
  logic [CLS_W-1:0]        out_class_q;
  logic [SEG_IW-1:0]       out_seg_q;
  logic [SEG_W-1:0]        out_hv_q;

  logic                    acc_cls_ok, acc_seg_ok, bin_cls_ok, bin_seg_ok;
  logic                    acc_fire, bin_fire;
  logic signed [CNT_W-1:0] acc_row_d [SEG_W];
  logic                    sat_hit_d;
  logic [SEG_W-1:0]        bin_bits_d;
  logic [NUM_CLASSES*SAMPLE_W-1:0] sample_pack;

  // Range checks only exist when the index width can encode unused values.
  if (NUM_CLASSES == (1 << CLS_W)) begin : g_cls_full
    assign acc_cls_ok = 1'b1;
    assign bin_cls_ok = 1'b1;
  end else begin : g_cls_part
    assign acc_cls_ok = (32'(hv.acc_class) < NUM_CLASSES);
    assign bin_cls_ok = (32'(hv.bin_class) < NUM_CLASSES);
  end

  if (SEG_COUNT == (1 << SEG_IW)) begin : g_seg_full
    assign acc_seg_ok = 1'b1;
    assign bin_seg_ok = 1'b1;
  end else begin : g_seg_part
    assign acc_seg_ok = (32'(hv.acc_seg) < SEG_COUNT);
    assign bin_seg_ok = (32'(hv.bin_seg) < SEG_COUNT);
  end

  assign acc_fire = hv.en && hv.acc_valid && acc_cls_ok && acc_seg_ok;
  assign bin_fire = hv.en && hv.bin_valid && bin_cls_ok && bin_seg_ok;

  // Next value of the addressed segment row; a counter at a rail holds and flags.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    sat_hit_d = 1'b0;
    for (int i = 0; i < SEG_W; i++) begin
      acc_row_d[i] = cnt_q[hv.acc_class][hv.acc_seg][i];
      if (hv.acc_hv[i]) begin
        if (acc_row_d[i] == CNT_MAX) sat_hit_d = 1'b1;
        else                         acc_row_d[i] = acc_row_d[i] + CNT_ONE;
      end else begin
        if (acc_row_d[i] == CNT_MIN) sat_hit_d = 1'b1;
        else                         acc_row_d[i] = acc_row_d[i] - CNT_ONE;
      end
    end
  end

  // Readout samples the registered counters, so a same-cycle write is not seen.
  always_comb begin
    bin_bits_d = '0;
    for (int i = 0; i < SEG_W; i++)
      bin_bits_d[i] = ~cnt_q[hv.bin_class][hv.bin_seg][i][CNT_W-1];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: the counter array is reset explicitly because a reset mid-stream must
      // discard partial hypervectors; this keeps it in flops rather than SRAM.
      for (int k = 0; k < NUM_CLASSES; k++) begin
        for (int s = 0; s < SEG_COUNT; s++)
          for (int i = 0; i < SEG_W; i++) cnt_q[k][s][i] <= '0;
        sample_q[k] <= '0;
      end
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_seg_q   <= '0;
      out_hv_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every read in this block sees the
      // pre-edge state, which is what makes read-before-write collisions work.
      if (hv.clr) begin
        for (int k = 0; k < NUM_CLASSES; k++) begin
          for (int s = 0; s < SEG_COUNT; s++)
            for (int i = 0; i < SEG_W; i++) cnt_q[k][s][i] <= '0;
          sample_q[k] <= '0;
        end
        sat_q <= 1'b0;
      end else if (acc_fire) begin
        cnt_q[hv.acc_class][hv.acc_seg] <= acc_row_d;
        if (sat_hit_d) sat_q <= 1'b1;
        if (hv.acc_seg == SEG_LAST && !(&sample_q[hv.acc_class]))
          sample_q[hv.acc_class] <= sample_q[hv.acc_class] + SAMPLE_W'(1);
      end

      out_valid_q <= bin_fire;
      if (bin_fire) begin
        out_class_q <= hv.bin_class;
        out_seg_q   <= hv.bin_seg;
        out_hv_q    <= bin_bits_d;
      end
    end
  end

  always_comb begin
    sample_pack = '0;
    for (int k = 0; k < NUM_CLASSES; k++)
      sample_pack[k*SAMPLE_W +: SAMPLE_W] = sample_q[k];
  end

  assign hv.out_valid  = out_valid_q;
  assign hv.out_class  = out_class_q;
  assign hv.out_seg    = out_seg_q;
  assign hv.out_hv     = out_hv_q;
  assign hv.sample_cnt = sample_pack;
  assign hv.sat_flag   = sat_q;
endmodule

// File: tb/tb_class_hv_accum.sv
// Directed bench for class_hv_accum with an integer reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_class_hv_accum;
  localparam int NC = 4, SC = 4, SW = 8, CW = 4, PW = 16;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  bit   chk_on = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  class_hv_accum_if #(.NUM_CLASSES(NC), .SEG_COUNT(SC), .SEG_W(SW), .SAMPLE_W(PW)) hv ();

  class_hv_accum #(.NUM_CLASSES(NC), .SEG_COUNT(SC), .SEG_W(SW), .CNT_W(CW), .SAMPLE_W(PW))
    dut (.clk(clk), .nrst(nrst), .hv(hv));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer counters clamped to the CNT_W signed range.
  int         m_cnt [NC][SC][SW];
  int         m_samp [NC];
  bit         m_sat = 1'b0;
  bit         e_valid = 1'b0;
  logic [1:0] e_cls = '0, e_seg = '0;
  logic [SW-1:0] e_hv = '0;
  localparam int LIM_HI = (1 << (CW - 1)) - 1;
  localparam int LIM_LO = -(1 << (CW - 1));

  task automatic model_clear();
    for (int k = 0; k < NC; k++) begin
      m_samp[k] = 0;
      for (int s = 0; s < SC; s++)
        for (int i = 0; i < SW; i++) m_cnt[k][s][i] = 0;
    end
    m_sat = 1'b0;
  endtask

  always @(negedge nrst) begin
    model_clear();
    e_valid = 1'b0;
    e_cls = '0;
    e_seg = '0;
    e_hv = '0;
  end

  always @(posedge clk) begin
    if (nrst) begin
      int c, s, v;
      e_valid = 1'b0;
      if (hv.en && hv.bin_valid) begin
        e_valid = 1'b1;
        e_cls = hv.bin_class;
        e_seg = hv.bin_seg;
        for (int i = 0; i < SW; i++) e_hv[i] = (m_cnt[hv.bin_class][hv.bin_seg][i] >= 0);
      end
      if (hv.clr) model_clear();
      else if (hv.en && hv.acc_valid) begin
        c = int'(hv.acc_class);
        s = int'(hv.acc_seg);
        for (int i = 0; i < SW; i++) begin
          v = m_cnt[c][s][i] + (hv.acc_hv[i] ? 1 : -1);
          if (v > LIM_HI || v < LIM_LO) m_sat = 1'b1;
          else m_cnt[c][s][i] = v;
        end
        if (s == SC - 1 && m_samp[c] < (1 << PW) - 1) m_samp[c]++;
      end
    end
  end

  always @(negedge clk) begin
    if (nrst && chk_on) begin
      logic [NC*PW-1:0] pack;
      for (int k = 0; k < NC; k++) pack[k*PW +: PW] = m_samp[k][PW-1:0];
      check("cyc_out_valid", 64'(hv.out_valid), 64'(e_valid));
      check("cyc_out_hv", 64'(hv.out_hv), 64'(e_hv));
      check("cyc_out_class", 64'(hv.out_class), 64'(e_cls));
      check("cyc_out_seg", 64'(hv.out_seg), 64'(e_seg));
      check("cyc_sample_cnt", 64'(hv.sample_cnt), 64'(pack));
      check("cyc_sat_flag", 64'(hv.sat_flag), 64'(m_sat));
    end
  end

  task automatic step(input bit e, input bit c, input bit av, input int ac, input int as,
                      input logic [SW-1:0] ahv, input bit bv, input int bc, input int bs);
    hv.en = e;
    hv.clr = c;
    hv.acc_valid = av;
    hv.acc_class = ac[1:0];
    hv.acc_seg = as[1:0];
    hv.acc_hv = ahv;
    hv.bin_valid = bv;
    hv.bin_class = bc[1:0];
    hv.bin_seg = bs[1:0];
    @(negedge clk);
  endtask

  task automatic acc(input int ac, input int as, input logic [SW-1:0] ahv);
    step(1'b1, 1'b0, 1'b1, ac, as, ahv, 1'b0, 0, 0);
  endtask

  task automatic bin(input int bc, input int bs);
    step(1'b1, 1'b0, 1'b0, 0, 0, '0, 1'b1, bc, bs);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 0, 0, '0, 1'b0, 0, 0);
  endtask

  initial begin
    hv.en = 1'b0; hv.clr = 1'b0; hv.acc_valid = 1'b0; hv.acc_class = '0; hv.acc_seg = '0;
    hv.acc_hv = '0; hv.bin_valid = 1'b0; hv.bin_class = '0; hv.bin_seg = '0;
    #12;
    check("rst_out_valid", 64'(hv.out_valid), 64'd0);
    check("rst_out_hv", 64'(hv.out_hv), 64'd0);
    check("rst_sample_cnt", 64'(hv.sample_cnt), 64'd0);
    check("rst_sat_flag", 64'(hv.sat_flag), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    chk_on = 1'b1;

    // Fresh state: every counter is zero, which reads back as 1.
    for (int s = 0; s < SC; s++) begin
      bin(0, s);
      check("zero_bin_valid", 64'(hv.out_valid), 64'd1);
      check("zero_bin_hv", 64'(hv.out_hv), 64'hFF);
      check("zero_bin_seg", 64'(hv.out_seg), 64'(s));
    end
    idle();
    check("idle_valid_low", 64'(hv.out_valid), 64'd0);
    check("idle_hv_holds", 64'(hv.out_hv), 64'hFF);

    // One full sample into class 2.
    for (int s = 0; s < SC; s++) acc(2, s, 8'hF0);
    check("c2_sample_cnt", 64'(hv.sample_cnt[2*PW +: PW]), 64'd1);
    for (int s = 0; s < SC; s++) begin
      bin(2, s);
      check("c2_bin_hv", 64'(hv.out_hv), 64'hF0);
    end

    // Drive class 1 seg 0 past both rails.
    for (int n = 0; n < 9; n++) acc(1, 0, 8'h01);
    check("c1_sat_flag", 64'(hv.sat_flag), 64'd1);
    bin(1, 0);
    check("c1_bin_hv", 64'(hv.out_hv), 64'h01);
    check("c1_bin_class", 64'(hv.out_class), 64'd1);
    check("c1_no_sample", 64'(hv.sample_cnt[1*PW +: PW]), 64'd0);

    // Same-address collision reads the old value; a different address is independent.
    step(1'b1, 1'b0, 1'b1, 3, 1, 8'h00, 1'b1, 3, 1);
    check("coll_pre_update", 64'(hv.out_hv), 64'hFF);
    bin(3, 1);
    check("coll_post_update", 64'(hv.out_hv), 64'h00);
    step(1'b1, 1'b0, 1'b1, 3, 2, 8'h0F, 1'b1, 2, 0);
    check("diff_addr_hv", 64'(hv.out_hv), 64'hF0);

    // Disabled strobes change nothing and produce no output.
    step(1'b0, 1'b0, 1'b1, 2, 0, 8'h00, 1'b1, 2, 0);
    check("en0_valid", 64'(hv.out_valid), 64'd0);
    bin(2, 0);
    check("en0_no_acc", 64'(hv.out_hv), 64'hF0);

    // Clear beats a same-cycle accumulate; the same-cycle readout sees pre-clear data.
    step(1'b1, 1'b1, 1'b1, 1, 3, 8'h00, 1'b1, 1, 0);
    check("clr_bin_pre", 64'(hv.out_hv), 64'h01);
    check("clr_sat_flag", 64'(hv.sat_flag), 64'd0);
    check("clr_sample_cnt", 64'(hv.sample_cnt), 64'd0);
    bin(1, 3);
    check("clr_acc_dropped", 64'(hv.out_hv), 64'hFF);
    bin(1, 0);
    check("clr_counters_zero", 64'(hv.out_hv), 64'hFF);

    // Clear still acts while disabled.
    acc(2, 0, 8'h00);
    bin(2, 0);
    check("pre_clr_en0", 64'(hv.out_hv), 64'h00);
    step(1'b0, 1'b1, 1'b0, 0, 0, '0, 1'b0, 0, 0);
    bin(2, 0);
    check("clr_en0_hv", 64'(hv.out_hv), 64'hFF);

    // Asynchronous reset after seg 1 of a partial sample.
    acc(0, 0, 8'h00);
    for (int n = 0; n < 9; n++) acc(0, 1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 0, 0, '0, 1'b1, 3, 2);
    #2;
    nrst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(hv.out_valid), 64'd0);
    check("mid_rst_hv", 64'(hv.out_hv), 64'd0);
    check("mid_rst_class", 64'(hv.out_class), 64'd0);
    check("mid_rst_seg", 64'(hv.out_seg), 64'd0);
    check("mid_rst_sat", 64'(hv.sat_flag), 64'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    for (int k = 0; k < NC; k++)
      for (int s = 0; s < SC; s++) begin
        bin(k, s);
        check("post_rst_hv", 64'(hv.out_hv), 64'hFF);
      end
    idle();
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
